// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of a single-outstanding
// memory port. Round-robin on ties, IDLE -> ISSUE -> WAIT transaction flow.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,

    // instruction-cache read port
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,

    // data-cache read/write port
    input  logic              d_req_valid,
    input  logic              d_req_write,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,

    // memory port
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,

    // status
    output logic              busy,
    output logic              owner,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // owner / last_grant encoding
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t state_q;
    state_t state_d;

    logic              last_grant_q;
    logic              owner_q;
    logic              req_write_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic              mem_req_valid_q;
    logic              busy_q;
    logic              i_resp_valid_q;
    logic              d_resp_valid_q;
    logic [DATA_W-1:0] i_resp_data_q;
    logic [DATA_W-1:0] d_resp_data_q;
    logic              proto_err_q;

    logic grant_d_c;
    logic grant_i_c;
    logic accept;
    logic take_resp;

    // Round-robin pick: D wins when alone, or on a tie when I was granted last.
    always_comb begin
        grant_d_c = d_req_valid && (!i_req_valid || (last_grant_q == OWN_I));
        grant_i_c = i_req_valid && !grant_d_c;
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the combinational handshake strobes.
    always_comb begin
        state_d     = state_q;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        accept      = 1'b0;
        take_resp   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_c) begin
                    d_req_ready = 1'b1;
                    accept      = 1'b1;
                    state_d     = ST_ISSUE;
                end else if (grant_i_c) begin
                    i_req_ready = 1'b1;
                    accept      = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response is only legal once the request has been handed off.
                if (mem_resp_valid) begin
                    take_resp = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latch, ownership and round-robin history, updated on acceptance.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_grant_q <= OWN_I;
            owner_q      <= OWN_I;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
        end else if (accept) begin
            last_grant_q <= grant_d_c;
            owner_q      <= grant_d_c;
            if (grant_d_c) begin
                req_write_q <= d_req_write;
                req_addr_q  <= d_req_addr;
                req_wdata_q <= d_req_wdata;
            end else begin
                // instruction fetches are always reads with no payload
                req_write_q <= 1'b0;
                req_addr_q  <= i_req_addr;
                req_wdata_q <= '0;
            end
        end
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_req_valid_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            mem_req_valid_q <= (state_d == ST_ISSUE);
            busy_q          <= (state_d != ST_IDLE);
        end
    end

    // Route the memory response to whichever side owns the transaction.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            i_resp_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b0;
            i_resp_data_q  <= '0;
            d_resp_data_q  <= '0;
        end else begin
            i_resp_valid_q <= take_resp && (owner_q == OWN_I);
            d_resp_valid_q <= take_resp && (owner_q == OWN_D);
            if (take_resp && (owner_q == OWN_I)) begin
                i_resp_data_q <= mem_resp_data;
            end
            if (take_resp && (owner_q == OWN_D)) begin
                // write acknowledges carry no data
                d_resp_data_q <= req_write_q ? '0 : mem_resp_data;
            end
        end
    end

    // Sticky flag for a memory response arriving when none is expected.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            proto_err_q <= 1'b0;
        end else if (mem_resp_valid && (state_q != ST_WAIT)) begin
            proto_err_q <= 1'b1;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_write = req_write_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign i_resp_valid  = i_resp_valid_q;
    assign i_resp_data   = i_resp_data_q;
    assign d_resp_valid  = d_resp_valid_q;
    assign d_resp_data   = d_resp_data_q;
    assign busy          = busy_q;
    assign owner         = owner_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 2 time units after each rising
// edge, outputs are sampled 1 time unit later.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    logic              clk;
    logic              n_rst;
    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_ready;
    logic              i_resp_valid;
    logic [DATA_W-1:0] i_resp_data;
    logic              d_req_valid;
    logic              d_req_write;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_req_ready;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;
    logic              mem_req_valid;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              busy;
    logic              owner;
    logic              proto_err;

    int n_cmp;
    int n_err;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_req_valid    (i_req_valid),
        .i_req_addr     (i_req_addr),
        .i_req_ready    (i_req_ready),
        .i_resp_valid   (i_resp_valid),
        .i_resp_data    (i_resp_data),
        .d_req_valid    (d_req_valid),
        .d_req_write    (d_req_write),
        .d_req_addr     (d_req_addr),
        .d_req_wdata    (d_req_wdata),
        .d_req_ready    (d_req_ready),
        .d_resp_valid   (d_resp_valid),
        .d_resp_data    (d_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy),
        .owner          (owner),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        n_rst          = 1'b0;
        i_req_valid    = 1'b0;
        i_req_addr     = '0;
        d_req_valid    = 1'b0;
        d_req_write    = 1'b0;
        d_req_addr     = '0;
        d_req_wdata    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        // ---- reset values ----
        tick();
        tick();
        #1;
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_owner",     32'(owner), 32'd0);
        chk("rst_mreqv",     32'(mem_req_valid), 32'd0);
        chk("rst_perr",      32'(proto_err), 32'd0);
        chk("rst_iresp",     32'(i_resp_valid), 32'd0);
        chk("rst_dresp",     32'(d_resp_valid), 32'd0);
        chk("rst_maddr",     32'(mem_req_addr), 32'd0);
        chk("rst_mwdata",    32'(mem_req_wdata), 32'd0);
        chk("rst_idata",     32'(i_resp_data), 32'd0);
        chk("rst_ddata",     32'(d_resp_data), 32'd0);

        // ---- tie right after reset release: D wins, write 0xBEEF to 0x0040 ----
        tick();
        n_rst         = 1'b1;
        i_req_valid   = 1'b1;
        i_req_addr    = 16'h0200;
        d_req_valid   = 1'b1;
        d_req_write   = 1'b1;
        d_req_addr    = 16'h0040;
        d_req_wdata   = 16'hBEEF;
        mem_req_ready = 1'b1;
        #1;
        chk("tie_dready",    32'(d_req_ready), 32'd1);
        chk("tie_iready",    32'(i_req_ready), 32'd0);
        tick();
        d_req_valid = 1'b0;
        #1;
        chk("tie_mreqv",     32'(mem_req_valid), 32'd1);
        chk("tie_mwrite",    32'(mem_req_write), 32'd1);
        chk("tie_maddr",     32'(mem_req_addr), 32'h0040);
        chk("tie_mwdata",    32'(mem_req_wdata), 32'hBEEF);
        chk("tie_owner",     32'(owner), 32'd1);
        chk("tie_busy",      32'(busy), 32'd1);
        chk("issue_iready",  32'(i_req_ready), 32'd0);
        tick();
        #1;
        chk("wait_mreqv",    32'(mem_req_valid), 32'd0);
        chk("wait_busy",     32'(busy), 32'd1);
        chk("wait_iready",   32'(i_req_ready), 32'd0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'h5555;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("wack_dvalid",   32'(d_resp_valid), 32'd1);
        chk("wack_ddata",    32'(d_resp_data), 32'd0);
        chk("wack_ivalid",   32'(i_resp_valid), 32'd0);
        chk("wack_busy",     32'(busy), 32'd0);
        chk("next_iready",   32'(i_req_ready), 32'd1);
        chk("next_dready",   32'(d_req_ready), 32'd0);
        tick();
        i_req_valid = 1'b0;
        #1;
        chk("dpulse_end",    32'(d_resp_valid), 32'd0);
        chk("i_owner",       32'(owner), 32'd0);
        chk("i_mwrite",      32'(mem_req_write), 32'd0);
        chk("i_maddr",       32'(mem_req_addr), 32'h0200);
        chk("i_mwdata",      32'(mem_req_wdata), 32'd0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'hAAAA;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("i1_ivalid",     32'(i_resp_valid), 32'd1);
        chk("i1_idata",      32'(i_resp_data), 32'hAAAA);
        chk("i1_dvalid",     32'(d_resp_valid), 32'd0);

        // ---- I read of 0x0100 with mem_req_ready held off for 3 cycles ----
        tick();
        mem_req_ready = 1'b0;
        i_req_valid   = 1'b1;
        i_req_addr    = 16'h0100;
        #1;
        chk("slow_iready",   32'(i_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mem_req_ready = (c == 3);
            #1;
            chk("slow_mreqv",  32'(mem_req_valid), 32'd1);
            chk("slow_maddr",  32'(mem_req_addr), 32'h0100);
            chk("slow_mwrite", 32'(mem_req_write), 32'd0);
            tick();
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'h1234;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("slow_ivalid",   32'(i_resp_valid), 32'd1);
        chk("slow_idata",    32'(i_resp_data), 32'h1234);
        chk("slow_busy",     32'(busy), 32'd0);
        chk("slow_dvalid",   32'(d_resp_valid), 32'd0);
        tick();
        #1;
        chk("slow_pulse",    32'(i_resp_valid), 32'd0);

        // ---- both requesters continuously valid: D,I,D,I,D,I back to back ----
        i_req_valid   = 1'b1;
        i_req_addr    = 16'h0500;
        d_req_valid   = 1'b1;
        d_req_write   = 1'b0;
        d_req_addr    = 16'h0600;
        mem_req_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            mem_resp_valid = 1'b0;
            #1;
            if (k > 0) begin
                chk("rr_dvalid", 32'(d_resp_valid), 32'((k - 1) % 2 == 0));
                chk("rr_ivalid", 32'(i_resp_valid), 32'((k - 1) % 2 == 1));
                chk("rr_busy",   32'(busy), 32'd0);
            end
            chk("rr_dready",   32'(d_req_ready), 32'(k % 2 == 0));
            chk("rr_iready",   32'(i_req_ready), 32'(k % 2 == 1));
            tick();
            chk("rr_owner",    32'(owner), 32'(k % 2 == 0));
            chk("rr_mreqv",    32'(mem_req_valid), 32'd1);
            tick();
            mem_resp_valid = 1'b1;
            mem_resp_data  = 16'(16'h0010 + k);
            tick();
        end
        mem_resp_valid = 1'b0;
        i_req_valid    = 1'b0;
        d_req_valid    = 1'b0;
        #1;
        chk("rr_last_iv",    32'(i_resp_valid), 32'd1);
        chk("rr_last_id",    32'(i_resp_data), 32'h0015);
        chk("rr_last_dv",    32'(d_resp_valid), 32'd0);
        chk("rr_perr",       32'(proto_err), 32'd0);

        // ---- handoff and response in the same ISSUE cycle: response ignored ----
        tick();
        d_req_valid   = 1'b1;
        d_req_addr    = 16'h0300;
        mem_req_ready = 1'b0;
        tick();
        d_req_valid    = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'h7777;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        chk("same_dvalid",   32'(d_resp_valid), 32'd0);
        chk("same_busy",     32'(busy), 32'd1);
        chk("same_mreqv",    32'(mem_req_valid), 32'd0);
        chk("same_perr",     32'(proto_err), 32'd1);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'h8888;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("same_dvalid2",  32'(d_resp_valid), 32'd1);
        chk("same_ddata",    32'(d_resp_data), 32'h8888);
        chk("same_busy2",    32'(busy), 32'd0);

        // ---- reset clears proto_err ----
        tick();
        n_rst = 1'b0;
        #1;
        chk("rst2_perr",     32'(proto_err), 32'd0);
        chk("rst2_ddata",    32'(d_resp_data), 32'd0);
        chk("rst2_maddr",    32'(mem_req_addr), 32'd0);
        chk("rst2_owner",    32'(owner), 32'd0);
        tick();
        n_rst = 1'b1;
        tick();

        // ---- response pulse in IDLE ----
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'h4321;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("idle_perr",     32'(proto_err), 32'd1);
        chk("idle_ivalid",   32'(i_resp_valid), 32'd0);
        chk("idle_dvalid",   32'(d_resp_valid), 32'd0);
        chk("idle_busy",     32'(busy), 32'd0);
        tick();
        tick();
        #1;
        chk("idle_perr_sticky", 32'(proto_err), 32'd1);

        // ---- reset during WAIT abandons the transaction ----
        i_req_valid   = 1'b1;
        i_req_addr    = 16'h0400;
        mem_req_ready = 1'b1;
        tick();
        i_req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk("rw_busy",       32'(busy), 32'd1);
        chk("rw_maddr",      32'(mem_req_addr), 32'h0400);
        n_rst = 1'b0;
        #1;
        chk("rw_rst_busy",   32'(busy), 32'd0);
        chk("rw_rst_perr",   32'(proto_err), 32'd0);
        chk("rw_rst_maddr",  32'(mem_req_addr), 32'd0);
        tick();
        n_rst = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'h9999;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("rw_ivalid",     32'(i_resp_valid), 32'd0);
        chk("rw_dvalid",     32'(d_resp_valid), 32'd0);
        chk("rw_perr",       32'(proto_err), 32'd1);
        chk("rw_busy_idle",  32'(busy), 32'd0);
        i_req_valid = 1'b1;
        #1;
        chk("rw_idle_ready", 32'(i_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width in bits.
REQ-002 Parameter DATA_W, default 16, memory data width in bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 n_rst  in  1  asynchronous active-low reset.
REQ-006 i_req_valid  in  1  instruction-cache read request.
REQ-007 i_req_addr  in  ADDR_W  instruction-cache read address.
REQ-008 i_req_ready  out  1  instruction-cache request accepted this cycle.
REQ-009 i_resp_valid  out  1  instruction-cache read data valid, one-cycle pulse.
REQ-010 i_resp_data  out  DATA_W  instruction-cache read data.
REQ-011 d_req_valid  in  1  data-cache request.
REQ-012 d_req_write  in  1  data-cache request type: 1 write, 0 read.
REQ-013 d_req_addr  in  ADDR_W  data-cache request address.
REQ-014 d_req_wdata  in  DATA_W  data-cache write data.
REQ-015 d_req_ready  out  1  data-cache request accepted this cycle.
REQ-016 d_resp_valid  out  1  data-cache read data or write acknowledge, one-cycle pulse.
REQ-017 d_resp_data  out  DATA_W  data-cache read data; 0 on a write acknowledge.
REQ-018 mem_req_valid  out  1  memory request valid.
REQ-019 mem_req_write / mem_req_addr / mem_req_wdata  out  1/ADDR_W/DATA_W  latched request fields.
REQ-020 mem_req_ready  in  1  memory accepts the request.
REQ-021 mem_resp_valid  in  1  memory response or write acknowledge.
REQ-022 mem_resp_data  in  DATA_W  memory read data.
REQ-023 busy  out  1  a transaction is in flight (state not IDLE).
REQ-024 owner  out  1  owner of the current or last transaction: 0 = I, 1 = D.
REQ-025 proto_err  out  1  sticky flag: mem_resp_valid was seen outside WAIT.

Function
REQ-026 States SHALL be IDLE, ISSUE and WAIT; at most one transaction is outstanding.
REQ-027 IDLE arbitration, when only one requester is valid: that requester wins.
REQ-028 IDLE arbitration, when both are valid: the requester not granted last wins (round-robin on last_grant).
REQ-029 In IDLE with a winner, the winner's *_req_ready SHALL be high combinationally in the same cycle.
REQ-030 On that IDLE acceptance, the block latches addr, write and wdata and sets owner and last_grant to the winner.
REQ-031 The IDLE acceptance moves the state to ISSUE.
REQ-032 For I requests, the latched write SHALL be 0 and wdata SHALL be 0.
REQ-033 *_req_ready SHALL be 0 in ISSUE and WAIT, and for the losing requester.
REQ-034 In ISSUE, mem_req_valid SHALL be 1 and the mem_req_* fields SHALL hold stable until mem_req_ready; on the cycle mem_req_ready is high, the state moves to WAIT.
REQ-035 In WAIT, on mem_resp_valid, the block registers the response to the owner: <owner>_resp_valid = 1 next cycle, for one cycle.
REQ-036 That response carries data = mem_resp_data for reads and 0 for writes, and the state returns to IDLE.
REQ-037 Latency: accept at cycle T, mem_req_valid at T+1; mem_resp_valid at cycle R gives resp_valid at R+1, and the next acceptance is possible at R+1.
REQ-038 mem_req_ready and mem_resp_valid in the same WAIT-entry cycle: the response SHALL NOT be taken; it is valid only from WAIT.
REQ-039 mem_resp_valid in IDLE or ISSUE SHALL be ignored for routing and SHALL set proto_err, which holds until reset.
REQ-040 A requester dropping valid before acceptance SHALL cause no transaction; valid held after acceptance SHALL be treated as a new request on the next IDLE.
REQ-041 The non-owner's resp_valid SHALL never assert.

Reset
REQ-042 While n_rst = 0: state = IDLE and last_grant = I, so the first tie goes to D.
REQ-043 While n_rst = 0: owner = 0, and all resp_valid, mem_req_valid, busy and proto_err are 0.
REQ-044 While n_rst = 0: all data and address outputs are 0.
REQ-045 Reset asserted mid-transaction SHALL abandon it immediately, with no response pulse after release.
REQ-046 The first acceptance SHALL be possible in the first clock edge after n_rst deasserts.

Verification
REQ-047 Tie after reset: I and D valid, D write addr 0x0040 data 0xBEEF, mem_req_ready same cycle, mem_resp_valid 2 cycles later -> d_req_ready at T, mem_req_write = 1 and addr 0x0040, d_resp_valid with data 0, then I granted next.
REQ-048 I read of 0x0100 with mem_req_ready delayed 3 cycles -> mem_req_valid and fields stable 4 cycles; mem_resp_data 0x1234 -> i_resp_valid pulse with 0x1234, busy low the same cycle.
REQ-049 Both requesters continuously valid for 6 transactions -> grants alternate D,I,D,I,D,I with no idle cycles beyond REQ-037.
REQ-050 mem_resp_valid pulsed in IDLE -> proto_err = 1 and stays 1; no resp_valid output.
REQ-051 n_rst asserted during WAIT, then mem_resp_valid after release -> no resp_valid, proto_err = 1, state IDLE.
